// File: rtl/press_classifier.sv
// Turns the debounced button level into one-cycle gesture pulses:
// short, double, long and auto-repeat while a long press is held.
module press_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DOUBLE_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic CPU_RESETN,
  input  logic btn_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int MAX_LD = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
  localparam int MAXC   = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int TW     = $clog2(MAXC);

  // The press edge itself is the first high sample, so the long-press hit
  // is one count earlier than the other timeouts.
  localparam logic [TW-1:0] L_HIT = TW'(LONG_CYCLES - 2);
  localparam logic [TW-1:0] D_HIT = TW'(DOUBLE_CYCLES - 1);
  localparam logic [TW-1:0] R_HIT = TW'(REPEAT_CYCLES - 1);

  if (LONG_CYCLES < 4 || DOUBLE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("press_classifier: LONG_CYCLES>=4, DOUBLE_CYCLES>=2, REPEAT_CYCLES>=2 required");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_PRESS1, S_LONG, S_WAIT2, S_PRESS2
  } state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic          r_armed;
  logic          w_tclr;
  logic          w_short, w_double, w_long, w_rep;
  logic          r_short, r_double, r_long, r_rep, r_busy;

  // State, timer, arming and registered outputs
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_armed  <= 1'b0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_rep    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || w_tclr) r_timer <= '0;
      else if (r_timer != '1)          r_timer <= r_timer + 1'b1;
      if (!btn_level) r_armed <= 1'b1;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_rep    <= w_rep;
      r_busy   <= (w_next != S_IDLE);
    end
  end

  // Next state; a level change always beats a coincident timeout
  always_comb begin
    w_next = r_state;
    w_tclr = 1'b0;
    case (r_state)
      S_IDLE:   if (r_armed && btn_level) w_next = S_PRESS1;
      S_PRESS1: begin
        if (!btn_level)              w_next = S_WAIT2;
        else if (r_timer == L_HIT)   w_next = S_LONG;
      end
      S_LONG: begin
        if (!btn_level)              w_next = S_IDLE;
        else if (r_timer == R_HIT)   w_tclr = 1'b1;
      end
      S_WAIT2: begin
        if (btn_level)               w_next = S_PRESS2;
        else if (r_timer == D_HIT)   w_next = S_IDLE;
      end
      S_PRESS2: if (!btn_level) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Event decode; the state qualifiers make these mutually exclusive
  always_comb begin
    w_short  = (r_state == S_WAIT2)  && !btn_level && (r_timer == D_HIT);
    w_double = (r_state == S_PRESS2) && !btn_level;
    w_long   = (r_state == S_PRESS1) &&  btn_level && (r_timer == L_HIT);
    w_rep    = (r_state == S_LONG)   &&  btn_level && (r_timer == R_HIT);
  end

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign repeat_tick  = r_rep;
  assign busy         = r_busy;

endmodule

// File: tb/tb_press_classifier.sv
// Directed gesture vectors for press_classifier at LONG=20, DOUBLE=8, REPEAT=5.
module tb_press_classifier;

  logic clk, CPU_RESETN, btn_level;
  logic short_press, double_press, long_press, repeat_tick, busy;

  press_classifier #(.LONG_CYCLES(20), .DOUBLE_CYCLES(8), .REPEAT_CYCLES(5)) dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN), .btn_level(btn_level),
    .short_press(short_press), .double_press(double_press),
    .long_press(long_press), .repeat_tick(repeat_tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ev[4];   // 0 short, 1 double, 2 long, 3 repeat
  int c_ev[4];
  int b_ev[4];
  int n_multi = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin n_ev[i] = 0; c_ev[i] = -1; end
  end

  always @(negedge clk) begin
    logic [3:0] w;
    w = {repeat_tick, long_press, double_press, short_press};
    for (int i = 0; i < 4; i++)
      if (w[i]) begin n_ev[i] <= n_ev[i] + 1; c_ev[i] <= cyc; end
    if ($countones(w) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic b);
    btn_level = b;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(input logic b, input int n);
    repeat (n) tick(b);
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) b_ev[i] = n_ev[i];
  endtask

  function automatic int d(input int i);
    return n_ev[i] - b_ev[i];
  endfunction

  int s;

  initial begin
    CPU_RESETN = 1'b1;
    btn_level  = 1'b0;
    #2 CPU_RESETN = 1'b0;
    #1 chk("rst_out", int'({short_press, double_press, long_press, repeat_tick, busy}), 0);
    ticks(1'b0, 3);
    CPU_RESETN = 1'b1;
    ticks(1'b0, 3);

    // short press: 5 high, release sampled at s+6, pulse at s+14
    snap(); s = cyc;
    tick(1'b1);
    chk("sp_busy_rise", int'(busy), 1);
    ticks(1'b1, 4);
    ticks(1'b0, 8);
    tick(1'b0);
    chk("sp_pulse", int'(short_press), 1);
    chk("sp_busy_fall", int'(busy), 0);
    ticks(1'b0, 3);
    chk("sp_cycle", c_ev[0], s + 14);
    chk("sp_count", d(0), 1);
    chk("sp_others", d(1) + d(2) + d(3), 0);

    // double press: second release sampled at s+11
    snap(); s = cyc;
    ticks(1'b1, 3); ticks(1'b0, 4); ticks(1'b1, 3);
    tick(1'b0);
    chk("dp_pulse", int'(double_press), 1);
    chk("dp_busy", int'(busy), 0);
    ticks(1'b0, 12);
    chk("dp_cycle", c_ev[1], s + 11);
    chk("dp_count", d(1), 1);
    chk("dp_no_short", d(0), 0);

    // long hold 42: long at s+20, repeats s+25..s+40
    snap(); s = cyc;
    ticks(1'b1, 27);
    chk("lp_cycle", c_ev[2], s + 20);
    chk("rt_first", c_ev[3], s + 25);
    ticks(1'b1, 15);
    tick(1'b0);
    ticks(1'b0, 10);
    chk("rt_last", c_ev[3], s + 40);
    chk("rt_count", d(3), 4);
    chk("lp_count", d(2), 1);
    chk("lp_no_release_evt", d(0) + d(1), 0);
    chk("lp_busy_end", int'(busy), 0);

    // release on the would-be long edge: no long, short 8 later
    snap(); s = cyc;
    ticks(1'b1, 19);
    tick(1'b0);
    ticks(1'b0, 10);
    chk("e1_no_long", d(2), 0);
    chk("e1_short_cycle", c_ev[0], s + 28);
    chk("e1_short_count", d(0), 1);

    // re-press on the WAIT2 timeout edge: double, no short
    snap(); s = cyc;
    ticks(1'b1, 2);
    ticks(1'b0, 8);
    ticks(1'b1, 2);
    tick(1'b0);
    ticks(1'b0, 10);
    chk("e2_no_short", d(0), 0);
    chk("e2_dp_count", d(1), 1);
    chk("e2_dp_cycle", c_ev[1], s + 13);

    // async reset mid-LONG_HOLD, while a repeat pulse is high
    ticks(1'b1, 25);
    chk("rs_pre_rep", int'(repeat_tick), 1);
    chk("rs_pre_busy", int'(busy), 1);
    #2 CPU_RESETN = 1'b0;
    #1 chk("rs_async_out", int'({short_press, double_press, long_press, repeat_tick, busy}), 0);
    ticks(1'b1, 2);
    CPU_RESETN = 1'b1;
    snap();
    ticks(1'b1, 30);
    chk("rs_held_no_evt", d(0) + d(1) + d(2) + d(3), 0);
    chk("rs_held_busy", int'(busy), 0);
    ticks(1'b0, 2);
    snap(); s = cyc;
    ticks(1'b1, 3);
    tick(1'b0);
    ticks(1'b0, 10);
    chk("rs_short_cycle", c_ev[0], s + 12);
    chk("rs_short_count", d(0), 1);

    chk("one_hot", n_multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
